// File: rtl/async_req_arbiter_pkg.sv
// Shared constants for async_req_arbiter: default widths, synchronizer depth,
// startup mask length and FSM state encoding.
package async_req_arbiter_pkg;

    localparam int unsigned N_REQ_DEF  = 4;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 32;

    // req synchronizer depth and number of post-reset cycles with req masked
    localparam int unsigned SYNC_STAGES    = 2;
    localparam int unsigned STARTUP_CYCLES = 2;
    localparam int unsigned STARTUP_CNT_W  = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        ACK   = ST_ACK
    } state_e;

endpackage

// File: rtl/async_req_arbiter_if.sv
// Requester handshake bundle plus shared write port.
//   req_async/addr_async/data_async : per-requester request and bundled payload
//   ack                             : per-requester level acknowledge
//   wr_en/wr_addr/wr_data/wr_ready  : shared single-clock write port
// slave = arbiter side, master = requesters/write-port side.
interface async_req_arbiter_if
    import async_req_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = N_REQ_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic [N_REQ-1:0]        req_async;
    logic [N_REQ*ADDR_W-1:0] addr_async;
    logic [N_REQ*DATA_W-1:0] data_async;
    logic [N_REQ-1:0]        ack;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    wr_ready;

    modport slave (
        input  req_async, addr_async, data_async, wr_ready,
        output ack, wr_en, wr_addr, wr_data
    );

    modport master (
        output req_async, addr_async, data_async, wr_ready,
        input  ack, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/async_req_arbiter_rr_arb_pick.sv
// Combinational round-robin picker: first set bit of req scanning upward
// from ptr+1 with wrap-around.
//   req   : request vector
//   ptr   : index of the last grant
//   win_c : winning index (0 when nothing requested)
//   any_c : at least one request set
module rr_arb_pick #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_c,
    output logic             any_c
);
    int unsigned cand;

    // Scan from lowest priority to highest so the highest-priority hit wins.
    always_comb begin
        win_c = '0;
        any_c = 1'b0;
        cand  = 0;
        for (int k = int'(N); k > 0; k--) begin
            cand = 32'(ptr) + 32'(k);
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[cand[IDX_W-1:0]]) begin
                win_c = IDX_W'(cand);
                any_c = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sync_2ff.sv
// Multi-flop level synchronizer, no reset.
//   clk : destination clock
//   d   : asynchronous input
//   q   : synchronized output (STAGES cycles latency)
module sync_2ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;

    always_ff @(posedge clk) begin
        sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];
endmodule

// File: rtl/async_req_arbiter.sv
// Round-robin arbiter sharing one write port among N_REQ requesters that use
// a 4-phase req/ack handshake from foreign clock domains.
//   clk, rst_n : core clock, async active-low reset
//   bus        : requester bundle + shared write port (slave side)
//   grant_id   : current owner, valid while busy
//   busy       : FSM not idle
//   proto_err  : sticky, req dropped before ack
module async_req_arbiter
    import async_req_arbiter_pkg::*;
#(
    parameter  int unsigned N_REQ  = N_REQ_DEF,
    parameter  int unsigned ADDR_W = ADDR_W_DEF,
    parameter  int unsigned DATA_W = DATA_W_DEF,
    localparam int unsigned IDX_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    async_req_arbiter_if.slave bus,
    output logic [IDX_W-1:0]   grant_id,
    output logic               busy,
    output logic               proto_err
);
    logic [N_REQ-1:0]         req_sync;
    logic [N_REQ-1:0]         req_s;
    logic [N_REQ-1:0]         pend;
    logic [STARTUP_CNT_W-1:0] start_cnt;
    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         win_c;
    logic                     any_c;
    state_e                   state;
    logic [N_REQ-1:0]         ack;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;

    // One synchronizer per request bit; payload is sampled raw since it is
    // stable well before req_s can rise.
    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_sync
        sync_2ff #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .d   (bus.req_async[i]),
            .q   (req_sync[i])
        );
    end

    // Unreset synchronizers may hold stale values; mask them after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_cnt <= '0;
        end else if (start_cnt != STARTUP_CNT_W'(STARTUP_CYCLES)) begin
            start_cnt <= start_cnt + STARTUP_CNT_W'(1);
        end
    end

    assign req_s = (start_cnt == STARTUP_CNT_W'(STARTUP_CYCLES)) ? req_sync : '0;
    assign pend  = req_s & ~ack;

    rr_arb_pick #(.N(N_REQ)) u_pick (
        .req   (pend),
        .ptr   (rr_ptr),
        .win_c (win_c),
        .any_c (any_c)
    );

    // Arbitration / write issue / acknowledge FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
            rr_ptr    <= IDX_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_c) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= bus.addr_async[32'(win_c) * ADDR_W +: ADDR_W];
                        wr_data  <= bus.data_async[32'(win_c) * DATA_W +: DATA_W];
                        grant_id <= win_c;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Early req drop: finish the write, flag it, pulse ack once.
                    if (!req_s[grant_id]) begin
                        proto_err <= 1'b1;
                    end
                    if (bus.wr_ready) begin
                        wr_en         <= 1'b0;
                        ack           <= '0;
                        ack[grant_id] <= 1'b1;
                        state         <= ACK;
                    end
                end
                ACK: begin
                    if (!req_s[grant_id]) begin
                        ack    <= '0;
                        rr_ptr <= grant_id;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack     = ack;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
endmodule

// File: tb/tb_async_req_arbiter.sv
// Scoreboard bench for async_req_arbiter: directed scenarios followed by
// randomized asynchronous requesters with a random write-ready pattern.
module tb_async_req_arbiter;
    import async_req_arbiter_pkg::*;

    localparam int unsigned N      = 4;
    localparam int unsigned AW     = 8;
    localparam int unsigned DW     = 32;
    localparam int unsigned IW     = $clog2(N);
    localparam int          BUDGET = 400;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic          proto_err;

    async_req_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    async_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .grant_id  (grant_id),
        .busy      (busy),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int tests      = 0;
    int fails      = 0;
    int accepted   = 0;
    int exp_writes = 0;
    logic [AW+DW-1:0] exp_q [N][$];
    int               order_q[$];
    bit               rand_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic expect_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q[i].push_back({a, d});
        exp_writes++;
    endtask

    task automatic set_payload(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.addr_async[i*AW +: AW] = a;
        bus.data_async[i*DW +: DW] = d;
    endtask

    task automatic wait_ack(input int i, input logic v, input string name);
        int n = 0;
        while (bus.ack[i] !== v && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(bus.ack[i]), 64'(v));
    endtask

    task automatic wait_wr_en(input string name);
        int n = 0;
        while (bus.wr_en !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(bus.wr_en), 64'd1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // Full 4-phase handshake for requester i with a fresh random payload.
    task automatic handshake(input int i);
        logic [AW-1:0] a = AW'($urandom);
        logic [DW-1:0] d = $urandom;
        set_payload(i, a, d);
        expect_write(i, a, d);
        bus.req_async[i] = 1'b1;
        wait_ack(i, 1'b1, "hs_ack_rise");
        bus.req_async[i] = 1'b0;
        wait_ack(i, 1'b0, "hs_ack_fall");
    endtask

    task automatic rand_requester(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            @(negedge clk);
            #($urandom_range(0, 3));
            handshake(i);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every accepted write.
    task automatic mon_cycle();
        int id;
        if (rst_n !== 1'b1) return;
        chk("onehot0_ack", 64'($onehot0(bus.ack)), 64'd1);
        chk("wr_en_implies_busy", 64'(!bus.wr_en || busy), 64'd1);
        if (bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
            accepted++;
            id = int'(grant_id);
            if (order_q.size() > 0) begin
                chk("grant_order", 64'(grant_id), 64'(order_q.pop_front()));
            end
            if (exp_q[id].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: requester %0d had no pending request at %0t", id, $time);
            end else begin
                chk("write_payload", 64'({bus.wr_addr, bus.wr_data}), 64'(exp_q[id].pop_front()));
            end
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        mon_cycle();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        rst_n          = 1'b0;
        bus.req_async  = '0;
        bus.addr_async = '0;
        bus.data_async = '0;
        bus.wr_ready   = 1'b1;

        // Reset release with req0 already high.
        a = AW'($urandom);
        d = $urandom;
        set_payload(0, a, d);
        expect_write(0, a, d);
        order_q.push_back(0);
        bus.req_async = 4'b0001;
        step(3);
        chk("rst_ack", 64'(bus.ack), 64'd0);
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        rst_n = 1'b1;
        step(1);
        chk("t1_masked_c1", 64'(bus.wr_en), 64'd0);
        step(1);
        chk("t1_masked_c2", 64'(bus.wr_en), 64'd0);
        step(1);
        chk("t1_wr_en", 64'(bus.wr_en), 64'd1);
        chk("t1_wr_addr", 64'(bus.wr_addr), 64'(a));
        chk("t1_wr_data", 64'(bus.wr_data), 64'(d));
        chk("t1_busy", 64'(busy), 64'd1);
        step(1);
        chk("t1_ack_rise", 64'(bus.ack), 64'b0001);
        bus.req_async[0] = 1'b0;
        step(2);
        chk("t1_ack_hold", 64'(bus.ack), 64'b0001);
        step(1);
        chk("t1_ack_fall", 64'(bus.ack), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);

        // Simultaneous requests after reset, then 0 and 2 again.
        apply_reset();
        order_q.push_back(0);
        order_q.push_back(1);
        order_q.push_back(2);
        order_q.push_back(3);
        fork
            handshake(0);
            handshake(1);
            handshake(2);
            handshake(3);
        join
        order_q.push_back(0);
        order_q.push_back(2);
        fork
            handshake(0);
            handshake(2);
        join
        step(2);
        chk("t2_order_drained", 64'(order_q.size()), 64'd0);

        // Stalled write port: payload must hold until accepted.
        bus.wr_ready = 1'b0;
        a = AW'($urandom);
        d = $urandom;
        set_payload(1, a, d);
        expect_write(1, a, d);
        order_q.push_back(1);
        bus.req_async[1] = 1'b1;
        wait_wr_en("t3_wr_en_rise");
        for (int k = 0; k < 5; k++) begin
            chk("t3_wr_en_hold", 64'(bus.wr_en), 64'd1);
            chk("t3_addr_hold", 64'(bus.wr_addr), 64'(a));
            chk("t3_data_hold", 64'(bus.wr_data), 64'(d));
            step(1);
        end
        chk("t3_no_ack_stalled", 64'(bus.ack), 64'd0);
        bus.wr_ready = 1'b1;
        step(1);
        chk("t3_ack_after_accept", 64'(bus.ack), 64'b0010);
        chk("t3_wr_en_drop", 64'(bus.wr_en), 64'd0);
        bus.req_async[1] = 1'b0;
        wait_ack(1, 1'b0, "t3_ack_fall");

        // Requester 1 drops req while its write is stalled.
        bus.wr_ready = 1'b0;
        a = AW'($urandom);
        d = $urandom;
        set_payload(1, a, d);
        expect_write(1, a, d);
        order_q.push_back(1);
        bus.req_async[1] = 1'b1;
        wait_wr_en("t4_wr_en_rise");
        chk("t4_no_err_yet", 64'(proto_err), 64'd0);
        bus.req_async[1] = 1'b0;
        step(3);
        chk("t4_proto_err_set", 64'(proto_err), 64'd1);
        chk("t4_write_pending", 64'(bus.wr_en), 64'd1);
        bus.wr_ready = 1'b1;
        step(1);
        chk("t4_ack_pulse", 64'(bus.ack), 64'b0010);
        step(1);
        chk("t4_ack_pulse_end", 64'(bus.ack), 64'd0);
        chk("t4_back_idle", 64'(busy), 64'd0);
        step(3);
        chk("t4_proto_err_sticky", 64'(proto_err), 64'd1);

        // Reset during ACK; req2 is re-served with a fresh write.
        a = AW'($urandom);
        d = $urandom;
        set_payload(2, a, d);
        expect_write(2, a, d);
        expect_write(2, a, d);
        order_q.push_back(2);
        order_q.push_back(2);
        bus.req_async[2] = 1'b1;
        wait_ack(2, 1'b1, "t5_ack_rise");
        chk("t5_ack_vec", 64'(bus.ack), 64'b0100);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ack", 64'(bus.ack), 64'd0);
        chk("t5_rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_proto_err", 64'(proto_err), 64'd0);
        chk("t5_rst_grant_id", 64'(grant_id), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(2, 1'b1, "t5_reserve_ack");
        bus.req_async[2] = 1'b0;
        wait_ack(2, 1'b0, "t5_ack_fall");

        // Random asynchronous requesters with random write-port back-pressure.
        fork
            begin
                fork
                    rand_requester(0, 6);
                    rand_requester(1, 6);
                    rand_requester(2, 6);
                    rand_requester(3, 6);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.wr_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.wr_ready = 1'b1;
        step(5);

        chk("end_proto_err", 64'(proto_err), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_writes_match", 64'(accepted), 64'(exp_writes));
        for (int i = 0; i < int'(N); i++) begin
            chk("end_pending_empty", 64'(exp_q[i].size()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/async_req_arbiter.md
Name: async_req_arbiter

Overview:
- Arbitration controller that shares one single-clock write port (e.g. the decoder's configuration register file) among N_REQ requesters living in foreign clock domains.
- Each requester uses a 4-phase level req/ack handshake with bundled address/data. Data must be held stable from req rise until ack rise.
- Each req bit passes through the team's 2-flop synchronizer. The block then arbitrates round-robin, issues one write per handshake to the shared port, and returns a level ack.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, write address width
- DATA_W, 32, write data width

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_async  in  N_REQ  per-requester level request, asynchronous to clk
- addr_async  in  N_REQ*ADDR_W  bundled address; requester i occupies bits [i*ADDR_W +: ADDR_W]
- data_async  in  N_REQ*DATA_W  bundled data, same packing
- ack  out  N_REQ  per-requester level acknowledge, registered
- wr_en  out  1  write strobe to shared port, registered
- wr_addr  out  ADDR_W  write address, registered
- wr_data  out  DATA_W  write data, registered
- wr_ready  in  1  shared port accepts the write when wr_en & wr_ready
- grant_id  out  clog2(N_REQ)  index of the current owner, valid while busy
- busy  out  1  FSM not in IDLE
- proto_err  out  1  sticky; set on a handshake violation

Behaviour:
- Reset values: ack=0, wr_en=0, wr_addr=0, wr_data=0, grant_id=0, busy=0, proto_err=0, FSM=IDLE, rr_ptr=N_REQ-1 (requester 0 wins first), startup counter=0.
- Synchronizers have no reset. For 2 cycles after rst_n deasserts, req_s is masked to 0 by a startup counter. Reset asserted mid-operation aborts everything immediately and re-arms the mask. Any partly issued write is dropped; the requester sees ack low and keeps waiting.
- req_s = synchronized req_async, 2-cycle latency. addr/data are sampled directly (no sync). They are safe because they are stable before req rises and req_s lags by 2 flops.
- FSM states:
  - IDLE: if any req_s[i] & ~ack[i], pick the winner g as the first set bit scanning from rr_ptr+1 with wrap-around. Next cycle: wr_en=1, wr_addr/wr_data = requester g's fields, grant_id=g, state ISSUE.
  - ISSUE: wr_en is held with stable addr/data until wr_ready. On wr_en & wr_ready: wr_en=0 and ack[g]=1 next cycle, state ACK.
  - ACK: hold ack[g]=1 until req_s[g]==0. Next cycle: ack[g]=0, rr_ptr=g, state IDLE. The earliest re-arbitration is the cycle after that.
- Total latency: req_async rise at edge 0 → wr_en high after edge 3 (sync 2 + decide 1). With wr_ready=1 → ack high after edge 4.
- At most one ack bit is high at any time. No new grant is issued while busy.
- Simultaneous requests are served in strict round-robin order relative to the last grant. Requests arriving during a grant wait in IDLE arbitration.
- Violation: req_s[g] falls while in ISSUE (before ack). The write still completes, proto_err is set, and the FSM passes through ACK for one cycle: ack[g] pulses 1 cycle, then the FSM returns to IDLE. proto_err clears only on reset.
- Requester must not re-raise req until it sees ack low; a re-raised req is treated as a new request.

Decomposition:
- Shared package: state encoding localparams ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_ACK=2'd2; SYNC_STAGES=2; startup mask count.
- Reuse the existing synchronizer module per req bit via generate.
- One natural new sub-module: rr_arb_pick, a combinational round-robin priority picker.
  - Inputs: request vector, pointer.
  - Outputs: winner index, any_valid.

Test Plan:
- Reset release with req_async=4'b0001 already high → no wr_en in the 2 masked cycles; wr_en rises with addr/data of req0; ack[0] follows; dropping req0 clears ack[0] 3 cycles later.
- req_async=4'b1111 held simultaneously, wr_ready=1, each requester drops req after ack → grant order 0,1,2,3. Then re-raise 0 and 2 → order 0,2 (pointer wrap from 3).
- wr_ready held 0 for 5 cycles during ISSUE → wr_en, wr_addr and wr_data stay stable all 5 cycles; exactly one write accepted; ack rises the cycle after acceptance.
- Requester 1 drops req during ISSUE → write still completes, proto_err=1 sticky, ack[1] high for exactly 1 cycle, FSM back to IDLE.
- rst_n asserted while in ACK with ack[2]=1 → all outputs 0 asynchronously; after release, the still-high req2 is re-served from scratch with a fresh write.
- Random async req toggling with a random-phase generator → invariant checks: onehot0(ack); wr_en only when busy; each handshake produces exactly one accepted write.
